// File: rtl/ibex_cheri_memchecker_pipe_if.sv
// ---------------------------------------------------------------------------
// ibex_cheri_memchecker_pipe_if
// Bundles the signals between the LSU/prefetch side and the pipelined CHERI
// memory checker.
//   master : LSU/prefetch side. Drives the authorising capability and the
//            request/grant/rvalid bus. Receives the gated write enable, the
//            exception vector and the status flags.
//   slave  : the checker (ibex_cheri_memchecker_pipe).
// Parameter TopWidth: width of the capability top; base/address use TopWidth-1.
// ---------------------------------------------------------------------------
interface ibex_cheri_memchecker_pipe_if #(
    parameter int TopWidth = 33
);
    logic                  auth_tag_i;
    logic                  auth_sealed_i;
    logic [TopWidth-2:0]   auth_base_i;
    logic [TopWidth-1:0]   auth_top_i;
    logic [30:0]           auth_perms_i;
    logic                  data_req_i;
    logic                  data_gnt_i;
    logic                  data_rvalid_i;
    logic [TopWidth-2:0]   data_addr_i;
    logic                  data_we_i;
    logic [1:0]            data_type_i;
    logic [3:0]            data_be_i;
    logic                  data_cap_i;
    logic                  data_first_access_i;
    logic                  data_we_o;
    logic                  exc_valid_o;
    logic [7:0]            cheri_mem_exc_o;
    logic                  instr_upper_exc_o;
    logic                  busy_o;
    logic                  full_o;
    logic                  err_o;

    modport master (
        output auth_tag_i, auth_sealed_i, auth_base_i, auth_top_i, auth_perms_i,
        output data_req_i, data_gnt_i, data_rvalid_i, data_addr_i, data_we_i,
        output data_type_i, data_be_i, data_cap_i, data_first_access_i,
        input  data_we_o, exc_valid_o, cheri_mem_exc_o, instr_upper_exc_o,
        input  busy_o, full_o, err_o
    );

    modport slave (
        input  auth_tag_i, auth_sealed_i, auth_base_i, auth_top_i, auth_perms_i,
        input  data_req_i, data_gnt_i, data_rvalid_i, data_addr_i, data_we_i,
        input  data_type_i, data_be_i, data_cap_i, data_first_access_i,
        output data_we_o, exc_valid_o, cheri_mem_exc_o, instr_upper_exc_o,
        output busy_o, full_o, err_o
    );
endinterface

// File: rtl/ibex_cheri_memchecker_pipe.sv
// ---------------------------------------------------------------------------
// ibex_cheri_memchecker_pipe
// Pipelined CHERI memory-access checker. Every granted request is checked
// against the authorising capability. The resulting exception vector is queued
// and released in order with the matching rvalid, with zero latency.
//
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus    : ibex_cheri_memchecker_pipe_if.slave. It carries the capability,
//            the request/grant/rvalid bus, data_we_o, exc_valid_o,
//            cheri_mem_exc_o, instr_upper_exc_o, busy_o, full_o and err_o.
//
// Parameters: DataMem (1 data port, 0 instruction port), MaxOutstanding
// (FIFO depth 1..8), TopWidth (capability top width).
//
// Optional feature macro: CHERI_MEMCHECK_STABLE_OUT_EN
//   When it is defined, cheri_mem_exc_o/instr_upper_exc_o hold the last popped
//   value between responses. When it is undefined, they read 0 whenever no pop
//   occurs.
// ---------------------------------------------------------------------------
module ibex_cheri_memchecker_pipe #(
    parameter bit DataMem        = 1'b1,
    parameter int MaxOutstanding = 2,
    parameter int TopWidth       = 33
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    ibex_cheri_memchecker_pipe_if.slave   bus
);
    localparam int AW = TopWidth - 1;
    localparam int EW = TopWidth + 1;
    localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CW = $clog2(MaxOutstanding + 1);

    // ---------------- combinational check ----------------
    logic [1:0]    w_lsb;
    logic [AW-1:0] w_start;
    logic [3:0]    w_size;
    logic [EW-1:0] w_start_ext;
    logic [EW-1:0] w_end;
    logic [EW-1:0] w_end4;
    logic          w_length;
    logic          w_upper;
    logic [7:0]    w_vec;
    logic          w_unused;

    // The lowest enabled byte gives the real start of a sub-word access.
    // With no byte enable set, the low bits are 3.
    always_comb begin
        w_lsb = 2'd3;
        if (DataMem) begin
            if (bus.data_be_i[0])      w_lsb = 2'd0;
            else if (bus.data_be_i[1]) w_lsb = 2'd1;
            else if (bus.data_be_i[2]) w_lsb = 2'd2;
            else                       w_lsb = 2'd3;
        end else begin
            w_lsb = 2'd0;
        end
    end

    always_comb begin
        w_size = 4'd2;
        if (!DataMem)             w_size = 4'd2;
        else if (bus.data_cap_i)  w_size = 4'd8;
        else begin
            case (bus.data_type_i)
                2'b00:   w_size = 4'd4;
                2'b01:   w_size = 4'd2;
                2'b10:   w_size = 4'd1;
                default: w_size = 4'd8;
            endcase
        end
    end

    assign w_start     = {bus.data_addr_i[AW-1:2], w_lsb};
    // The two extra high bits keep start+size from wrapping past the top.
    assign w_start_ext = {2'b00, w_start};
    assign w_end       = w_start_ext + {{(EW-4){1'b0}}, w_size};
    assign w_end4      = w_start_ext + {{(EW-3){1'b0}}, 3'd4};
    assign w_length    = (w_start_ext < {2'b00, bus.auth_base_i}) ||
                         (w_end > {1'b0, bus.auth_top_i});
    assign w_upper     = !DataMem && (w_end4 > {1'b0, bus.auth_top_i});

    assign w_vec[0] = ~bus.auth_tag_i;
    assign w_vec[1] = bus.auth_sealed_i;
    assign w_vec[2] = ~DataMem & ~bus.auth_perms_i[1];
    assign w_vec[3] = DataMem & ~bus.data_we_i & ~bus.auth_perms_i[2];
    assign w_vec[4] = DataMem & bus.data_we_i & ~bus.auth_perms_i[3];
    assign w_vec[5] = w_length;
    assign w_vec[6] = bus.data_cap_i & ~bus.data_we_i & ~bus.auth_perms_i[4];
    assign w_vec[7] = bus.data_cap_i & bus.data_we_i & ~bus.auth_perms_i[5];

    assign bus.data_we_o = bus.data_we_i & ~|w_vec;

    assign w_unused = ^{bus.auth_perms_i[30:6], bus.auth_perms_i[0],
                        bus.data_addr_i[1:0], bus.data_first_access_i,
                        bus.data_be_i, bus.data_type_i};

    // ---------------- in-order exception FIFO ----------------
    logic [8:0]    r_mem [MaxOutstanding];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_last;
    logic          r_err;

    logic          w_push, w_pop, w_empty, w_full;
    logic          w_push_ok, w_overflow, w_underflow;
    logic [8:0]    w_entry, w_head, w_out;
    logic [PW-1:0] w_wr_ptr_inc, w_rd_ptr_inc;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(MaxOutstanding));
    assign w_push      = bus.data_req_i & bus.data_gnt_i;
    assign w_pop       = bus.data_rvalid_i & ~w_empty;
    // A pop frees the head slot in the same cycle, so a push into a full FIFO
    // is fine while it is popped.
    assign w_push_ok   = w_push & (~w_full | w_pop);
    assign w_overflow  = w_push & w_full & ~w_pop;
    assign w_underflow = bus.data_rvalid_i & w_empty;

    // The second half of a split access inherits the faults of the first half.
    assign w_entry = (DataMem && !bus.data_first_access_i) ?
                     {w_upper, w_vec | r_last} : {w_upper, w_vec};

    assign w_wr_ptr_inc = (r_wr_ptr == PW'(MaxOutstanding - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_inc = (r_rd_ptr == PW'(MaxOutstanding - 1)) ? '0 : r_rd_ptr + 1'b1;
    assign w_head       = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MaxOutstanding; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= w_wr_ptr_inc;
            end
            if (w_pop) r_rd_ptr <= w_rd_ptr_inc;
            if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
            if (DataMem && w_push && bus.data_first_access_i) r_last <= w_vec;
            if (w_overflow || w_underflow) r_err <= 1'b1;
        end
    end

`ifdef CHERI_MEMCHECK_STABLE_OUT_EN
    logic [8:0] r_out;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      r_out <= '0;
        else if (w_pop) r_out <= w_head;
    end
    // The head bypasses the output register, so the pop cycle has no latency.
    assign w_out = w_pop ? w_head : r_out;
`else
    assign w_out = w_pop ? w_head : 9'd0;
`endif

    assign bus.exc_valid_o       = w_pop;
    assign bus.cheri_mem_exc_o   = w_out[7:0];
    assign bus.instr_upper_exc_o = w_out[8];
    assign bus.busy_o            = ~w_empty;
    assign bus.full_o            = w_full;
    assign bus.err_o             = r_err;
endmodule

// File: tb/tb_ibex_cheri_memchecker_pipe.sv
// ---------------------------------------------------------------------------
// tb_ibex_cheri_memchecker_pipe
// Two instances: a data port (u_dut_d) and an instruction port (u_dut_i).
// Both have MaxOutstanding=2. A queue-based reference model checks each
// instance every cycle at the negative edge. The model uses the spec rules
// for start/size/bounds/permissions and an in-order scoreboard.
// ---------------------------------------------------------------------------
module tb_ibex_cheri_memchecker_pipe;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ibex_cheri_memchecker_pipe_if #(.TopWidth(33)) dif ();
    ibex_cheri_memchecker_pipe_if #(.TopWidth(33)) iif ();

    ibex_cheri_memchecker_pipe #(.DataMem(1'b1), .MaxOutstanding(MAXO), .TopWidth(33))
        u_dut_d (.clk_i(clk), .rst_i(rst), .bus(dif.slave));
    ibex_cheri_memchecker_pipe #(.DataMem(1'b0), .MaxOutstanding(MAXO), .TopWidth(33))
        u_dut_i (.clk_i(clk), .rst_i(rst), .bus(iif.slave));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: {upper, exc[7:0]} for one request, straight from the rules.
    function automatic logic [8:0] model_exc(input bit dm, input logic [31:0] addr,
            input bit we, input logic [1:0] ty, input logic [3:0] be, input bit cap,
            input bit tag, input bit sealed, input logic [31:0] base,
            input logic [32:0] top, input logic [30:0] p);
        longint start, size;
        int lsb;
        logic [8:0] v;
        lsb = 3;
        for (int i = 3; i >= 0; i--) if (be[i]) lsb = i;
        start = dm ? (longint'(addr & 32'hFFFF_FFFC) + lsb) : longint'(addr & 32'hFFFF_FFFC);
        if (!dm)          size = 2;
        else if (cap)     size = 8;
        else if (ty == 0) size = 4;
        else if (ty == 1) size = 2;
        else if (ty == 2) size = 1;
        else              size = 8;
        v[0] = !tag;
        v[1] = sealed;
        v[2] = !dm && !p[1];
        v[3] = dm && !we && !p[2];
        v[4] = dm && we && !p[3];
        v[5] = (start < longint'(base)) || (start + size > longint'(top));
        v[6] = cap && !we && !p[4];
        v[7] = cap && we && !p[5];
        v[8] = !dm && (start + 4 > longint'(top));
        return v;
    endfunction

    // Model state
    logic [8:0] dq[$];
    logic [8:0] iq[$];
    bit         d_err, i_err;
    logic [7:0] d_last;
    logic [8:0] d_out, i_out;

    task automatic model_reset();
        dq.delete(); iq.delete();
        d_err = 0; i_err = 0; d_last = '0; d_out = '0; i_out = '0;
    endtask

    task automatic check_update();
        logic [8:0] v, e, entry;
        bit push, pop;
        // ---- data port ----
        v = model_exc(1'b1, dif.data_addr_i, dif.data_we_i, dif.data_type_i, dif.data_be_i,
                      dif.data_cap_i, dif.auth_tag_i, dif.auth_sealed_i, dif.auth_base_i,
                      dif.auth_top_i, dif.auth_perms_i);
        push = dif.data_req_i && dif.data_gnt_i;
        pop  = dif.data_rvalid_i && dq.size() > 0;
`ifdef CHERI_MEMCHECK_STABLE_OUT_EN
        e = pop ? dq[0] : d_out;
`else
        e = pop ? dq[0] : 9'd0;
`endif
        chk("d_exc_valid", dif.exc_valid_o, pop);
        chk("d_exc", dif.cheri_mem_exc_o, e[7:0]);
        chk("d_upper", dif.instr_upper_exc_o, e[8]);
        chk("d_we_o", dif.data_we_o, dif.data_we_i && (v[7:0] == 0));
        chk("d_busy", dif.busy_o, dq.size() > 0);
        chk("d_full", dif.full_o, dq.size() == MAXO);
        chk("d_err", dif.err_o, d_err);
        if (pop) $display("data pop exc=%02h", dq[0][7:0]);
        entry = dif.data_first_access_i ? v : (v | {1'b0, d_last});
        if (push && dif.data_first_access_i) d_last = v[7:0];
        if (dif.data_rvalid_i && dq.size() == 0) d_err = 1;
        if (pop) d_out = dq.pop_front();
        if (push) begin
            if (dq.size() < MAXO) dq.push_back(entry);
            else d_err = 1;
        end
        // ---- instruction port ----
        v = model_exc(1'b0, iif.data_addr_i, iif.data_we_i, iif.data_type_i, iif.data_be_i,
                      iif.data_cap_i, iif.auth_tag_i, iif.auth_sealed_i, iif.auth_base_i,
                      iif.auth_top_i, iif.auth_perms_i);
        push = iif.data_req_i && iif.data_gnt_i;
        pop  = iif.data_rvalid_i && iq.size() > 0;
`ifdef CHERI_MEMCHECK_STABLE_OUT_EN
        e = pop ? iq[0] : i_out;
`else
        e = pop ? iq[0] : 9'd0;
`endif
        chk("i_exc_valid", iif.exc_valid_o, pop);
        chk("i_exc", iif.cheri_mem_exc_o, e[7:0]);
        chk("i_upper", iif.instr_upper_exc_o, e[8]);
        chk("i_busy", iif.busy_o, iq.size() > 0);
        chk("i_full", iif.full_o, iq.size() == MAXO);
        chk("i_err", iif.err_o, i_err);
        if (pop) $display("instr pop exc=%02h upper=%0b", iq[0][7:0], iq[0][8]);
        if (iif.data_rvalid_i && iq.size() == 0) i_err = 1;
        if (pop) i_out = iq.pop_front();
        if (push) begin
            if (iq.size() < MAXO) iq.push_back(v);
            else i_err = 1;
        end
    endtask

    task automatic tick_post();
        check_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        tick_post();
    endtask

    task automatic d_auth(input bit tag, input bit sealed, input logic [31:0] base,
                          input logic [32:0] top, input logic [30:0] perms);
        dif.auth_tag_i = tag; dif.auth_sealed_i = sealed; dif.auth_base_i = base;
        dif.auth_top_i = top; dif.auth_perms_i = perms;
    endtask

    task automatic d_drive(input bit req, input bit gnt, input bit rv, input logic [31:0] addr,
                           input bit we, input logic [1:0] ty, input logic [3:0] be,
                           input bit cap, input bit first);
        dif.data_req_i = req; dif.data_gnt_i = gnt; dif.data_rvalid_i = rv;
        dif.data_addr_i = addr; dif.data_we_i = we; dif.data_type_i = ty;
        dif.data_be_i = be; dif.data_cap_i = cap; dif.data_first_access_i = first;
    endtask

    task automatic i_drive(input bit req, input bit rv, input logic [31:0] addr);
        iif.data_req_i = req; iif.data_gnt_i = req; iif.data_rvalid_i = rv;
        iif.data_addr_i = addr; iif.data_we_i = 0; iif.data_type_i = 2'b00;
        iif.data_be_i = 4'hF; iif.data_cap_i = 0; iif.data_first_access_i = 0;
    endtask

    task automatic d_idle();
        d_drive(0, 0, 0, 32'h1000, 0, 2'b00, 4'hF, 0, 1);
    endtask

    initial begin
        model_reset();
        d_auth(1, 0, 32'h1000, 33'h1010, 31'h4);
        d_drive(0, 0, 1, 32'h1000, 0, 2'b00, 4'hF, 0, 1);
        iif.auth_tag_i = 1; iif.auth_sealed_i = 0; iif.auth_base_i = 32'h2000;
        iif.auth_top_i = 33'h2002; iif.auth_perms_i = 31'h2;
        i_drive(0, 0, 32'h2000);
        // Reset state, with rvalid high during reset
        @(negedge clk);
        chk("rst_exc_valid", dif.exc_valid_o, 1'b0);
        chk("rst_busy", dif.busy_o, 1'b0);
        chk("rst_full", dif.full_o, 1'b0);
        chk("rst_err", dif.err_o, 1'b0);
        chk("rst_exc", dif.cheri_mem_exc_o, 8'h00);
        d_idle();
        rst = 0;
        @(posedge clk); #1;

        // Word load in bounds, then byte load past top
        d_drive(1, 1, 0, 32'h100C, 0, 2'b00, 4'hF, 0, 1); step();
        d_drive(0, 0, 1, 32'h100C, 0, 2'b00, 4'hF, 0, 1);
        @(negedge clk);
        chk("ld_ok_valid", dif.exc_valid_o, 1'b1);
        chk("ld_ok_exc", dif.cheri_mem_exc_o, 8'h00);
        tick_post();
        d_drive(1, 1, 0, 32'h1010, 0, 2'b10, 4'b0001, 0, 1); step();
        d_drive(0, 0, 1, 32'h1010, 0, 2'b10, 4'b0001, 0, 1);
        @(negedge clk);
        chk("ld_len_exc", dif.cheri_mem_exc_o, 8'h20);
        tick_post();

        // Store without store perm, then an OK load: fills the FIFO
        d_drive(1, 1, 0, 32'h1000, 1, 2'b00, 4'hF, 0, 1);
        @(negedge clk);
        chk("st_we_o", dif.data_we_o, 1'b0);
        tick_post();
        d_drive(1, 1, 0, 32'h1000, 0, 2'b00, 4'hF, 0, 1); step();
        d_idle();
        @(negedge clk);
        chk("two_full", dif.full_o, 1'b1);
        tick_post();
        d_drive(0, 0, 1, 32'h1000, 0, 2'b00, 4'hF, 0, 1);
        @(negedge clk);
        chk("st_exc", dif.cheri_mem_exc_o, 8'h10);
        tick_post();
        d_idle();
        @(negedge clk);
`ifdef CHERI_MEMCHECK_STABLE_OUT_EN
        chk("stable_hold", dif.cheri_mem_exc_o, 8'h10);
`else
        chk("idle_zero", dif.cheri_mem_exc_o, 8'h00);
`endif
        tick_post();
        d_drive(0, 0, 1, 32'h1000, 0, 2'b00, 4'hF, 0, 1);
        @(negedge clk);
        chk("ld2_exc", dif.cheri_mem_exc_o, 8'h00);
        tick_post();

        // Split access: first half has tag=0, the second half inherits it
        d_auth(0, 0, 32'h1000, 33'h1010, 31'h4);
        d_drive(1, 1, 0, 32'h1004, 0, 2'b00, 4'hF, 0, 1); step();
        d_auth(1, 0, 32'h1000, 33'h1010, 31'h4);
        d_drive(1, 1, 0, 32'h1008, 0, 2'b00, 4'hF, 0, 0); step();
        d_drive(0, 0, 1, 32'h1000, 0, 2'b00, 4'hF, 0, 1);
        @(negedge clk);
        chk("split1_tag", dif.cheri_mem_exc_o[0], 1'b1);
        tick_post();
        @(negedge clk);
        chk("split2_tag", dif.cheri_mem_exc_o[0], 1'b1);
        tick_post();

        // Capability-width load without load-cap perm
        d_drive(1, 1, 0, 32'h1000, 0, 2'b00, 4'hF, 1, 1); step();
        d_drive(0, 0, 1, 32'h1000, 0, 2'b00, 4'hF, 0, 1);
        @(negedge clk);
        chk("cap_ld_exc", dif.cheri_mem_exc_o, 8'h40);
        tick_post();

        // Full FIFO with simultaneous grant+rvalid, then overflow
        d_drive(1, 1, 0, 32'h1000, 0, 2'b00, 4'hF, 0, 1); step(); step();
        d_drive(1, 1, 1, 32'h1000, 0, 2'b00, 4'hF, 0, 1); step();
        d_idle();
        @(negedge clk);
        chk("full_keep", dif.full_o, 1'b1);
        chk("full_no_err", dif.err_o, 1'b0);
        tick_post();
        d_drive(1, 1, 0, 32'h1000, 0, 2'b00, 4'hF, 0, 1); step();
        d_drive(0, 0, 1, 32'h1000, 0, 2'b00, 4'hF, 0, 1); step(); step(); step();
        d_idle();
        @(negedge clk);
        chk("err_sticky", dif.err_o, 1'b1);
        tick_post();

        // Instruction port: upper parcel beyond top
        i_drive(1, 0, 32'h2000); step();
        i_drive(0, 1, 32'h2000);
        @(negedge clk);
        chk("fetch_len", iif.cheri_mem_exc_o[5], 1'b0);
        chk("fetch_upper", iif.instr_upper_exc_o, 1'b1);
        tick_post();
        i_drive(0, 0, 32'h2000);

        // Reset with two entries queued, then a late response
        d_drive(1, 1, 0, 32'h1000, 1, 2'b00, 4'hF, 0, 1); step(); step();
        d_idle();
        rst = 1;
        @(negedge clk);
        chk("mid_rst_busy", dif.busy_o, 1'b0);
        chk("mid_rst_err", dif.err_o, 1'b0);
        rst = 0;
        model_reset();
        @(posedge clk); #1;
        d_drive(0, 0, 1, 32'h1000, 0, 2'b00, 4'hF, 0, 1);
        @(negedge clk);
        chk("late_rv_valid", dif.exc_valid_o, 1'b0);
        tick_post();
        d_idle();
        @(negedge clk);
        chk("late_rv_err", dif.err_o, 1'b1);
        tick_post();

        // Reset again, then randomized traffic on both ports
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        @(posedge clk); #1;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] base;
            base = 32'h1000 + ($urandom_range(0, 8) << 2);
            d_auth($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, base,
                   {1'b0, base} + 33'($urandom_range(0, 40)), 31'($urandom));
            d_drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
                    (dq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0),
                    32'h0FF0 + ($urandom_range(0, 20) << 2), 1'($urandom), 2'($urandom),
                    4'($urandom), $urandom_range(0, 4) == 0, 1'($urandom));
            iif.auth_tag_i = $urandom_range(0, 9) != 0;
            iif.auth_sealed_i = $urandom_range(0, 9) == 0;
            iif.auth_base_i = base + 32'h1000;
            iif.auth_top_i = {1'b0, base} + 33'h1000 + 33'($urandom_range(0, 24));
            iif.auth_perms_i = 31'($urandom);
            i_drive($urandom_range(0, 1) == 1,
                    (iq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0),
                    32'h1FF8 + ($urandom_range(0, 12) << 2));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
